// File: rtl/mem_arbiter_if.sv
// Bundle of all request, response and status signals of the two-port memory
// arbiter. The slave modport is the arbiter's view. The master modport is
// the view of the surrounding requesters and memory.
interface mem_arbiter_if #(
  parameter int LINE_W = 256
);
  // instruction-side requester (port 0)
  logic              p0_enable_i;
  logic              p0_write_i;
  logic [31:0]       p0_addr_i;
  logic [LINE_W-1:0] p0_data_i;
  logic [LINE_W-1:0] p0_data_o;
  logic              p0_ack_o;

  // data-cache requester (port 1)
  logic              p1_enable_i;
  logic              p1_write_i;
  logic [31:0]       p1_addr_i;
  logic [LINE_W-1:0] p1_data_i;
  logic [LINE_W-1:0] p1_data_o;
  logic              p1_ack_o;

  // shared memory side
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  // status
  logic [1:0]        grant_o;
  logic              busy_o;
  logic              timeout_o;

  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p0_data_o, p0_ack_o,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i,
    output grant_o, busy_o, timeout_o
  );

  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p0_data_o, p0_ack_o,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i,
    input  grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. It shares one memory port between an
// instruction-side requester (p0) and a data-cache requester (p1).
// A granted request is captured into registers and held stable until memory
// acks. A watchdog counter raises a sticky timeout flag when a grant runs
// TO_CYC cycles without an ack.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin. When it is not defined, p1 always wins a tie.
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int TO_CYC = 1023
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam int CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC);

  state_t            state;
  state_t            state_next;
  logic              pick0;
  logic              pick1;
  logic              enable_q;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_q;
  logic              granted;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_p1;
`endif

  assign granted = (state != IDLE);

  // Arbitration in IDLE picks a port. A grant ends only on a memory ack.
  always_comb begin
    state_next = state;
    pick0      = 1'b0;
    pick1      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p0_enable_i && bus.p1_enable_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (last_p1) pick0 = 1'b1;
          else         pick1 = 1'b1;
`else
          pick1 = 1'b1;
`endif
        end else if (bus.p0_enable_i) begin
          pick0 = 1'b1;
        end else if (bus.p1_enable_i) begin
          pick1 = 1'b1;
        end
        if (pick0)      state_next = GNT0;
        else if (pick1) state_next = GNT1;
      end
      GNT0, GNT1: begin
        if (bus.mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register. mem_enable is registered alongside it so the two always agree.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      enable_q <= 1'b0;
    end else begin
      state    <= state_next;
      enable_q <= (state_next != IDLE);
    end
  end

  // Capture the winner's request so later input changes cannot disturb memory.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (pick0) begin
      write_q <= bus.p0_write_i;
      addr_q  <= bus.p0_addr_i;
      data_q  <= bus.p0_data_i;
    end else if (pick1) begin
      write_q <= bus.p1_write_i;
      addr_q  <= bus.p1_addr_i;
      data_q  <= bus.p1_data_i;
    end
  end

  // Count granted cycles without an ack. The counter saturates, and the timeout flag stays set until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pick0 || pick1) begin
        cnt <= '0;
      end else if (granted && !bus.mem_ack_i && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX - CNT_W'(1)) timeout_q <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember the most recent grant so the next tie goes to the other port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_p1 <= 1'b1;
    end else if (pick0) begin
      last_p1 <= 1'b0;
    end else if (pick1) begin
      last_p1 <= 1'b1;
    end
  end
`endif

  assign bus.p0_ack_o     = bus.mem_ack_i && (state == GNT0);
  assign bus.p1_ack_o     = bus.mem_ack_i && (state == GNT1);
  assign bus.p0_data_o    = (state == GNT0) ? bus.mem_data_i : '0;
  assign bus.p1_data_o    = (state == GNT1) ? bus.mem_data_i : '0;
  assign bus.mem_enable_o = enable_q;
  assign bus.mem_write_o  = write_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign bus.grant_o      = {state == GNT1, state == GNT0};
  assign bus.busy_o       = enable_q;
  assign bus.timeout_o    = timeout_q;

endmodule
